// File: rtl/systolic_ctrl_pkg.sv
// Shared types and defaults for the systolic array sequencer.
// Optional performance counters are enabled with SYSTOLIC_CTRL_PERF_EN.
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } ctrl_state_e;

  localparam int DW_DEF    = 32;
  localparam int K_MAX_DEF = 1024;

endpackage

// File: rtl/systolic_ctrl_if.sv
// Job control, tile-buffer read port and skewed array lanes of systolic_ctrl.
// SYSTOLIC_CTRL_PERF_EN adds perf_cycles/perf_jobs to the controller side.
interface systolic_ctrl_if #(
  parameter int N  = 256,
  parameter int M  = 256,
  parameter int DW = 32,
  parameter int AW = 10
);
  logic                   start;
  logic                   abort;
  logic [AW:0]            k_len;
  logic                   busy;
  logic                   done;
  logic                   a_rd_en;
  logic                   b_rd_en;
  logic [AW-1:0]          rd_addr;
  logic [N-1:0][DW-1:0]   a_rd_data;
  logic [M-1:0][DW-1:0]   b_rd_data;
  logic                   arr_rst;
  logic [N-1:0][DW-1:0]   data_inA;
  logic [M-1:0][DW-1:0]   data_inB;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]            perf_cycles;
  logic [31:0]            perf_jobs;

  modport slave (
    input  start, abort, k_len, a_rd_data, b_rd_data,
    output busy, done, a_rd_en, b_rd_en, rd_addr, arr_rst, data_inA, data_inB,
    output perf_cycles, perf_jobs
  );
  modport master (
    output start, abort, k_len, a_rd_data, b_rd_data,
    input  busy, done, a_rd_en, b_rd_en, rd_addr, arr_rst, data_inA, data_inB,
    input  perf_cycles, perf_jobs
  );
`else
  modport slave (
    input  start, abort, k_len, a_rd_data, b_rd_data,
    output busy, done, a_rd_en, b_rd_en, rd_addr, arr_rst, data_inA, data_inB
  );
  modport master (
    output start, abort, k_len, a_rd_data, b_rd_data,
    input  busy, done, a_rd_en, b_rd_en, rd_addr, arr_rst, data_inA, data_inB
  );
`endif

endinterface

// File: rtl/systolic_ctrl_skew.sv
// DEPTH-stage lane delay with async reset and synchronous flush; DEPTH 0 is a wire.
// Latency DEPTH cycles, no backpressure (free-running shift).
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst, flush};
      assign dout = din;
    end else begin : g_shift
      logic [DEPTH-1:0][DW-1:0] sr;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sr <= '0;
        end else if (flush) begin
          sr <= '0;
        end else begin
          sr[0] <= din;
          for (int s = 1; s < DEPTH; s++) sr[s] <= sr[s-1];
        end
      end

      assign dout = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer: clear array, stream k_len A/B vectors with diagonal skew, drain N+M, pulse done.
// Latency start->done 1+k_len+N+M+1 cycles; no backpressure. SYSTOLIC_CTRL_PERF_EN adds perf counters.
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int N     = 256,
  parameter int M     = 256,
  parameter int DW    = DW_DEF,
  parameter int K_MAX = K_MAX_DEF
) (
  input logic           clk,
  input logic           rst,
  systolic_ctrl_if.slave bus
);

  localparam int AW  = $clog2(K_MAX);
  localparam int DCW = $clog2(N + M + 1);
  localparam logic [AW:0]    KMAX_W     = (AW+1)'(K_MAX);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(N + M);

  ctrl_state_e          state;
  logic [AW:0]          klen_q;
  logic [AW:0]          feed_cnt;
  logic [DCW-1:0]       drain_cnt;
  logic                 rd_vld;
  logic                 flush;
  logic [N-1:0][DW-1:0] a_in, a_out;
  logic [M-1:0][DW-1:0] b_in, b_out;

  assign flush = bus.abort && (state == CLEAR || state == FEED || state == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.a_rd_en <= 1'b0;
      bus.b_rd_en <= 1'b0;
      bus.rd_addr <= '0;
      bus.arr_rst <= 1'b0;
      klen_q      <= '0;
      feed_cnt    <= '0;
      drain_cnt   <= '0;
      rd_vld      <= 1'b0;
    end else begin
      // Buffer data returns one cycle after the strobe.
      rd_vld      <= bus.a_rd_en;
      bus.done    <= 1'b0;
      bus.arr_rst <= 1'b0;
      if (flush) begin
        state       <= IDLE;
        bus.busy    <= 1'b0;
        bus.a_rd_en <= 1'b0;
        bus.b_rd_en <= 1'b0;
        bus.arr_rst <= 1'b1;
        rd_vld      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              state       <= CLEAR;
              bus.busy    <= 1'b1;
              bus.arr_rst <= 1'b1;
              klen_q      <= (bus.k_len > KMAX_W) ? KMAX_W : bus.k_len;
            end
          end
          CLEAR: begin
            if (klen_q == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state       <= FEED;
              bus.a_rd_en <= 1'b1;
              bus.b_rd_en <= 1'b1;
              bus.rd_addr <= '0;
              feed_cnt    <= (AW+1)'(1);
            end
          end
          FEED: begin
            if (feed_cnt == klen_q) begin
              state       <= DRAIN;
              bus.a_rd_en <= 1'b0;
              bus.b_rd_en <= 1'b0;
              drain_cnt   <= DCW'(1);
            end else begin
              bus.rd_addr <= feed_cnt[AW-1:0];
              feed_cnt    <= feed_cnt + 1'b1;
            end
          end
          DRAIN: begin
            if (drain_cnt == DRAIN_LAST) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
          DONE: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Zero fill: slots carry data only while a returned vector is valid.
  assign a_in = rd_vld ? bus.a_rd_data : '0;
  assign b_in = rd_vld ? bus.b_rd_data : '0;

  generate
    for (genvar i = 0; i < N; i++) begin : g_a
      skew_delay_line #(.DEPTH(i), .DW(DW)) u_skew (
        .clk(clk), .rst(rst), .flush(flush), .din(a_in[i]), .dout(a_out[i])
      );
    end
    for (genvar j = 0; j < M; j++) begin : g_b
      skew_delay_line #(.DEPTH(j), .DW(DW)) u_skew (
        .clk(clk), .rst(rst), .flush(flush), .din(b_in[j]), .dout(b_out[j])
      );
    end
  endgenerate

  assign bus.data_inA = a_out;
  assign bus.data_inB = b_out;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] job_cyc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_cyc         <= '0;
      bus.perf_cycles <= '0;
      bus.perf_jobs   <= '0;
    end else begin
      if (state == IDLE && bus.start && !bus.abort) job_cyc <= 32'd1;
      else if (bus.busy)                            job_cyc <= job_cyc + 32'd1;
      if (state == DONE) begin
        bus.perf_cycles <= job_cyc;
        bus.perf_jobs   <= bus.perf_jobs + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl (N=M=4, K_MAX=8) with a small MAC-array and tile-buffer model.
module tb_systolic_ctrl;

  localparam int N = 4, M = 4, DW = 32, K_MAX = 8, AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  systolic_ctrl_if #(.N(N), .M(M), .DW(DW), .AW(AW)) ifc ();

  systolic_ctrl #(.N(N), .M(M), .DW(DW), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  // Tile buffers: A lanes return k+1, B lanes return 2, one cycle after the strobe.
  always @(posedge clk) begin
    if (ifc.a_rd_en) for (int i = 0; i < N; i++) ifc.a_rd_data[i] <= 32'(ifc.rd_addr) + 32'd1;
    if (ifc.b_rd_en) for (int j = 0; j < M; j++) ifc.b_rd_data[j] <= 32'd2;
  end

  // Output-stationary array: A moves right, B moves down, each PE accumulates a*b.
  logic [31:0] pa [N][M];
  logic [31:0] pb [N][M];
  int          acc [N][M];

  function automatic logic [31:0] ain(int i, int j);
    if (j == 0) return ifc.data_inA[i];
    return pa[i][j-1];
  endfunction

  function automatic logic [31:0] bin(int i, int j);
    if (i == 0) return ifc.data_inB[j];
    return pb[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        if (rst || ifc.arr_rst) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= 0;
        end else begin
          pa[i][j]  <= ain(i, j);
          pb[i][j]  <= bin(i, j);
          acc[i][j] <= acc[i][j] + int'(ain(i, j) * bin(i, j));
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the CLEAR cycle (one cycle after start was sampled).
  task automatic launch(input logic [AW:0] k);
    ifc.start = 1'b1;
    ifc.k_len = k;
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int exp_t);
    int t = 1;
    while (!ifc.done && t < 100) begin
      tick();
      t++;
    end
    check(tag, t, exp_t);
    tick();
  endtask

  initial begin
    int rd_cnt, dn, done_t, first, last;
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    ifc.k_len = '0;

    // Reset values
    #1;
    check("rst_busy", ifc.busy, 0);
    check("rst_done", ifc.done, 0);
    check("rst_rd_en", {ifc.a_rd_en, ifc.b_rd_en}, 0);
    check("rst_arr_rst", ifc.arr_rst, 0);
    check("rst_rd_addr", ifc.rd_addr, 0);
    check("rst_lanes", |{ifc.data_inA, ifc.data_inB}, 0);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("rst_perf_cycles", ifc.perf_cycles, 0);
    check("rst_perf_jobs", ifc.perf_jobs, 0);
`endif
    tick();
    rst = 1'b0;
    tick();

    // k_len=3: skew timing, done latency 13, array result 12 everywhere
    launch(3);
    check("clear_arr_rst", ifc.arr_rst, 1);
    check("clear_busy", ifc.busy, 1);
    rd_cnt = 0; dn = 0; done_t = -1; first = -1; last = -1;
    for (int t = 1; t <= 14; t++) begin
      if (ifc.a_rd_en) begin
        rd_cnt++;
        check("feed_rd_addr", ifc.rd_addr, t - 2);
      end
      if (ifc.data_inA[2] != 0) begin
        if (first < 0) first = t;
        last = t;
        check("lane_a2_val", ifc.data_inA[2], t - 4);
      end
      if (t == 3) check("lane_a0_t3", ifc.data_inA[0], 1);
      if (t == 6) check("lane_b3_t6", ifc.data_inB[3], 2);
      if (ifc.done) begin
        dn++;
        done_t = t;
      end
      tick();
    end
    check("feed_rd_cnt", rd_cnt, 3);
    check("lane_a2_first", first, 5);
    check("lane_a2_last", last, 7);
    check("job_done_t", done_t, 13);
    check("job_done_cnt", dn, 1);
    check("job_idle_busy", ifc.busy, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++)
        check($sformatf("acc_%0d_%0d", i, j), acc[i][j], 12);

    // k_len=0: arr_rst pulse, done two cycles after start, no reads
    launch(0);
    check("k0_arr_rst", ifc.arr_rst, 1);
    rd_cnt = ifc.a_rd_en | ifc.b_rd_en;
    tick();
    check("k0_done", ifc.done, 1);
    rd_cnt += ifc.a_rd_en | ifc.b_rd_en;
    tick();
    rd_cnt += ifc.a_rd_en | ifc.b_rd_en;
    check("k0_rd_cnt", rd_cnt, 0);
    check("k0_idle", ifc.busy, 0);

    // start with abort in IDLE: abort wins
    ifc.start = 1'b1;
    ifc.abort = 1'b1;
    ifc.k_len = 2;
    tick();
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    check("sa_busy", ifc.busy, 0);
    check("sa_arr_rst", ifc.arr_rst, 0);
    tick();

    // abort during FEED cycle 2
    launch(5);
    tick();
    tick();
    ifc.abort = 1'b1;
    tick();
    ifc.abort = 1'b0;
    check("abort_busy", ifc.busy, 0);
    check("abort_arr_rst", ifc.arr_rst, 1);
    check("abort_rd_en", ifc.a_rd_en | ifc.b_rd_en, 0);
    check("abort_lanes", |{ifc.data_inA, ifc.data_inB}, 0);
    dn = 0;
    for (int t = 0; t < 20; t++) begin
      dn += int'(ifc.done);
      tick();
    end
    check("abort_no_done", dn, 0);

    // k_len above K_MAX saturates to 8 reads
    launch(12);
    rd_cnt = 0; done_t = -1;
    for (int t = 1; t <= 22; t++) begin
      rd_cnt += int'(ifc.a_rd_en);
      if (ifc.done) done_t = t;
      tick();
    end
    check("sat_rd_cnt", rd_cnt, 8);
    check("sat_done_t", done_t, 18);

    // start held high while busy: one job, one done
    ifc.start = 1'b1;
    ifc.k_len = 1;
    tick();
    dn = 0; done_t = -1;
    for (int t = 1; t <= 20; t++) begin
      if (ifc.done) begin
        dn++;
        done_t = t;
        ifc.start = 1'b0;
      end
      tick();
    end
    ifc.start = 1'b0;
    check("held_done_cnt", dn, 1);
    check("held_done_t", done_t, 11);
    check("held_idle", ifc.busy, 0);

    // rst mid-DRAIN, then a normal job
    launch(2);
    repeat (5) tick();
    check("mid_drain_busy", ifc.busy, 1);
    check("mid_drain_lane_a3", ifc.data_inA[3], 1);
    rst = 1'b1;
    #1;
    check("arst_busy", ifc.busy, 0);
    check("arst_rd_addr", ifc.rd_addr, 0);
    check("arst_lanes", |{ifc.data_inA, ifc.data_inB}, 0);
    check("arst_ctl", {ifc.done, ifc.arr_rst, ifc.a_rd_en, ifc.b_rd_en}, 0);
    tick();
    rst = 1'b0;
    tick();
    launch(1);
    run_to_done("post_rst_done_t", 11);

`ifdef SYSTOLIC_CTRL_PERF_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    launch(5);
    run_to_done("perf_job1_done_t", 15);
    launch(5);
    run_to_done("perf_job2_done_t", 15);
    check("perf_jobs", ifc.perf_jobs, 2);
    check("perf_cycles", ifc.perf_cycles, 1 + 5 + N + M + 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
